// File: rtl/pc_sequencer_rv32i.sv
// pc_sequencer_rv32i: RV32I PC owner and instruction-fetch sequencer (req/ack memory, valid/ready decode).
// Optional `PC_MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VECTOR and pulse misalign_err.
module pc_sequencer_rv32i #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        misalign_err
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_d;
  logic [31:0] pc, pc_d, tgt, addr_d, instr_d, ipc_d;
  logic kill, kill_d, mis, req_d, valid_d, err_d, load;
`ifdef PC_MISALIGN_TRAP_EN
  assign mis = |redir_pc[1:0];
  assign tgt = mis ? TRAP_VECTOR : redir_pc;
`else
  logic unused_bits;
  assign unused_bits = ^{TRAP_VECTOR, redir_pc[1:0]};
  assign mis = 1'b0;
  assign tgt = {redir_pc[31:2], 2'b00};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= 32'h0000_0013;
      if_pc        <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      kill         <= kill_d;
      imem_req     <= req_d;
      imem_addr    <= addr_d;
      if_valid     <= valid_d;
      if_instr     <= instr_d;
      if_pc        <= ipc_d;
      misalign_err <= err_d;
    end
  end
  // A killed or redirected ack parks in IDLE for one cycle so imem_req drops before the new fetch.
  always_comb begin
    state_d = (state == IDLE) ? REQ :
              (state == REQ)  ? (imem_ack ? ((kill || redir_valid) ? IDLE : HOLD) : REQ) :
              (state == HOLD) ? ((redir_valid || if_ready) ? REQ : HOLD) : IDLE;
    pc_d    = redir_valid ? tgt : (state == HOLD && if_ready) ? pc + 32'd4 : pc;
    kill_d  = state == REQ && !imem_ack && (kill || redir_valid);
  end
  // imem_addr is frozen for the whole REQ so the memory sees a stable address until ack.
  always_comb begin
    load    = state == REQ && state_d == HOLD;
    req_d   = state_d == REQ;
    valid_d = state_d == HOLD;
    addr_d  = (state == REQ) ? imem_addr : pc_d;
    instr_d = load ? imem_rdata : if_instr;
    ipc_d   = load ? pc : if_pc;
    err_d   = redir_valid && mis;
  end
endmodule

// File: tb/tb_pc_sequencer_rv32i.sv
// tb_pc_sequencer_rv32i: scoreboard bench for pc_sequencer_rv32i; fetch and transfer queues checked by monitors.
module tb_pc_sequencer_rv32i;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ack, if_valid, if_ready, redir_valid, misalign_err;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, redir_pc;
  int compared = 0, mismatched = 0;
  int lat = 0, cnt = 0;
  logic [31:0] fetch_q[$];
  logic [63:0] xfer_q[$];
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_TGT = 32'h0000_0100;
  localparam logic        MIS_ERR = 1'b1;
`else
  localparam logic [31:0] MIS_TGT = 32'h0000_0200;
  localparam logic        MIS_ERR = 1'b0;
`endif

  pc_sequencer_rv32i dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Memory: acks after lat wait cycles, word at address a is ~a.
  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = ~imem_addr;
  always @(posedge clk) cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && imem_req && imem_ack) begin
    if (fetch_q.size() == 0) chk("fetch_unexpected", imem_addr, 32'hDEAD_BEEF);
    else chk("fetch_addr", imem_addr, fetch_q.pop_front());
  end

  always @(negedge clk) if (rst_n && if_valid && if_ready) begin
    logic [63:0] e;
    if (xfer_q.size() == 0) chk("xfer_unexpected", if_pc, 32'hDEAD_BEEF);
    else begin
      e = xfer_q.pop_front();
      chk("xfer_pc", if_pc, e[63:32]);
      chk("xfer_instr", if_instr, e[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] pc);
    for (int n = 0; n < 40 && !(if_valid && if_pc == pc); n++) tick();
    if (!(if_valid && if_pc == pc)) chk("wait_valid_timeout", if_pc, pc);
  endtask

  task automatic accept(input logic [31:0] pc);
    wait_valid(pc);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid = 1'b1;
    redir_pc    = t;
    tick();
    redir_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    if_ready = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_err", {31'b0, misalign_err}, 32'h0);
    // Zero-wait stream with decode always ready.
    fetch_q = '{32'h0, 32'h4, 32'h8};
    xfer_q  = '{{32'h0, ~32'h0}, {32'h4, ~32'h4}};
    if_ready = 1'b1;
    rst_n = 1'b1;
    tick();       chk("c1_addr", imem_addr, 32'h0); chk("c1_req", {31'b0, imem_req}, 32'h1);
    tick(); tick(); chk("c3_addr", imem_addr, 32'h4); chk("c3_req", {31'b0, imem_req}, 32'h1);
    tick(); tick(); chk("c5_addr", imem_addr, 32'h8); chk("c5_req", {31'b0, imem_req}, 32'h1);
    if_ready = 1'b0;
    tick();
    // Decode stall: held instruction stays put, no new fetch.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, if_valid}, 32'h1);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, ~32'h8);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      tick();
    end
    // Three-cycle memory wait.
    lat = 3;
    xfer_q.push_back({32'h8, ~32'h8});
    fetch_q.push_back(32'hC);
    xfer_q.push_back({32'hC, ~32'hC});
    accept(32'h8);
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr, 32'hC);
      chk("wait_req", {31'b0, imem_req}, 32'h1);
      chk("wait_valid", {31'b0, if_valid}, 32'h0);
      tick();
    end
    // Redirect while a fetch is outstanding: 0x10 word is dropped.
    fetch_q.push_back(32'h10);
    fetch_q.push_back(32'h200);
    accept(32'hC);
    redirect(32'h200);
    chk("kill_addr_hold", imem_addr, 32'h10);
    wait_valid(32'h200);
    // Redirect in HOLD with same-cycle if_ready: transfer counts, redirect wins.
    lat = 0;
    xfer_q.push_back({32'h200, ~32'h200});
    fetch_q.push_back(32'h40);
    if_ready = 1'b1;
    redirect(32'h40);
    if_ready = 1'b0;
    chk("hold_redir_addr", imem_addr, 32'h40);
    xfer_q.push_back({32'h40, ~32'h40});
    fetch_q.push_back(32'h44);
    accept(32'h40);
    // Misaligned redirect discards 0x44 in HOLD.
    wait_valid(32'h44);
    fetch_q.push_back(MIS_TGT);
    redirect(32'h202);
    chk("mis_err_pulse", {31'b0, misalign_err}, {31'b0, MIS_ERR});
    chk("mis_addr", imem_addr, MIS_TGT);
    tick();
    chk("mis_err_clear", {31'b0, misalign_err}, 32'h0);
    xfer_q.push_back({MIS_TGT, ~MIS_TGT});
    fetch_q.push_back(MIS_TGT + 32'd4);
    accept(MIS_TGT);
    // PC wrap from 0xFFFF_FFFC to 0.
    wait_valid(MIS_TGT + 32'd4);
    fetch_q.push_back(32'hFFFF_FFFC);
    xfer_q.push_back({32'hFFFF_FFFC, 32'h0000_0003});
    fetch_q.push_back(32'h0);
    xfer_q.push_back({32'h0, ~32'h0});
    redirect(32'hFFFF_FFFC);
    accept(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    // Redirect in the same cycle as a zero-wait ack: word dropped, req gap, then new fetch.
    fetch_q.push_back(32'h4);
    fetch_q.push_back(32'h80);
    xfer_q.push_back({32'h80, ~32'h80});
    accept(32'h0);
    chk("ackredir_addr", imem_addr, 32'h4);
    redirect(32'h80);
    chk("ackredir_gap", {31'b0, imem_req}, 32'h0);
    tick();
    chk("ackredir_req", {31'b0, imem_req}, 32'h1);
    chk("ackredir_new", imem_addr, 32'h80);
    fetch_q.push_back(32'h84);
    accept(32'h80);
    repeat (4) tick();
    chk("fetch_q_empty", fetch_q.size(), 32'h0);
    chk("xfer_q_empty", xfer_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
